// File: rtl/apb_bus_master.sv
// APB initiator: converts single-beat requests into SETUP/ACCESS transfers on a
// two-slave peripheral bus, with address decode, PREADY timeout and response pulse.
module apb_bus_master #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic [1:0]        PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA0,
  input  logic              PREADY0,
  input  logic              PSLVERR0,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic              PREADY1,
  input  logic              PSLVERR1
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e            state;
  logic [7:0]        cnt;
  logic [1:0]        region;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;

  assign region = req_addr[ADDR_W-1 -: 2];

  // Only the slave currently selected is observed; the other is ignored.
  always_comb begin
    sel_ready = PREADY0;
    sel_err   = PSLVERR0;
    sel_rdata = PRDATA0;
    if (PSEL[1]) begin
      sel_ready = PREADY1;
      sel_err   = PSLVERR1;
      sel_rdata = PRDATA1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      PADDR     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
    end else begin
      case (state)
        StIdle: begin
          if (req_valid) begin
            PWRITE    <= req_write;
            PADDR     <= req_addr;
            PWDATA    <= req_wdata;
            req_ready <= 1'b0;
            if (region[1]) begin
              // Unmapped region: respond with an error without touching the bus.
              state     <= StResp;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state <= StSetup;
              PSEL  <= region[0] ? 2'b10 : 2'b01;
            end
          end
        end
        StSetup: begin
          PENABLE <= 1'b1;
          cnt     <= '0;
          state   <= StAccess;
        end
        StAccess: begin
          if (sel_ready) begin
            state     <= StResp;
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            rsp_rdata <= (!PWRITE && !sel_err) ? sel_rdata : '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
          end else if (cnt == TimeoutLast) begin
            state     <= StResp;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        StResp: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/apb_bus_master.md
Name: apb_bus_master

Overview:
- APB initiator that turns single-beat requests from the system-side controller into APB SETUP/ACCESS transfers.
- Sits on the requester side of the peripheral bus and drives the GPIO and UART register slaves through per-slave PSEL lines.
- Decodes the target from the address, waits on PREADY, and returns read data and error status through a one-cycle response pulse.
- Guards against hung slaves with a PREADY timeout.

Parameters:
- ADDR_W, 8, request/PADDR width; bits [ADDR_W-1:ADDR_W-2] select the region.
- DATA_W, 8, request/PWDATA/PRDATA width.
- TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY before abort; legal range 1..255.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
- rsp_err  out  1  slave error, timeout, or unmapped address.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  2  one-hot slave select; bit0 = GPIO, bit1 = UART.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PRDATA0  in  DATA_W  GPIO read data.
- PREADY0  in  1  GPIO ready.
- PSLVERR0  in  1  GPIO error.
- PRDATA1  in  DATA_W  UART read data.
- PREADY1  in  1  UART ready.
- PSLVERR1  in  1  UART error.

Behaviour:
- Reset (asynchronous, immediate): state = IDLE; req_ready = 1; rsp_valid, rsp_err, rsp_rdata, PADDR, PSEL, PENABLE, PWRITE, PWDATA and the timeout counter are all 0. Reset mid-transfer drops PSEL/PENABLE at once and no response is issued.
- Address decode on req_addr[MSB:MSB-1]:
  - 00 = GPIO (PSEL = 01)
  - 01 = UART (PSEL = 10)
  - 1x = unmapped
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On the edge where req_valid && req_ready: latch write, addr and wdata into PWRITE/PADDR/PWDATA.
  - Mapped address: go to SETUP.
  - Unmapped address: go to RESP with err = 1 and rdata = 0; no PSEL is ever asserted.
- SETUP (exactly 1 cycle): PSEL one-hot per decode, PENABLE = 0, req_ready = 0; then go to ACCESS.
- ACCESS:
  - PSEL held, PENABLE = 1, PADDR/PWRITE/PWDATA stable.
  - Only the selected slave's PREADY/PSLVERR/PRDATA are observed; the other slave's inputs are ignored.
  - On an edge with PREADY = 1:
    - capture rdata = PRDATA if read, else 0;
    - err = PSLVERR;
    - a read with PSLVERR = 1 returns rdata = 0;
    - go to RESP.
  - Timeout counter clears on entry to ACCESS and increments each ACCESS cycle without PREADY.
  - If no PREADY arrives in TIMEOUT ACCESS cycles, go to RESP with err = 1, rdata = 0.
  - PREADY in the same cycle the counter reaches TIMEOUT counts as success (PREADY has priority).
- RESP (1 cycle):
  - rsp_valid = 1 with rsp_rdata/rsp_err.
  - PSEL = 0, PENABLE = 0, req_ready = 0; then go to IDLE.
  - rsp_rdata/rsp_err hold their value until the next RESP; rsp_valid is high only in RESP.
- Latency:
  - Mapped transfer, zero-wait slave: accept at edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid in N+3, next accept at edge N+4 at the earliest.
  - Each wait state adds one cycle.
  - Unmapped: rsp_valid in the cycle after accept.
- PADDR/PWRITE/PWDATA keep their last value outside transfers; PSEL and PENABLE are never both nonzero outside SETUP/ACCESS.
- Requests presented while req_ready = 0 are not accepted and must be held by the requester.

Test Plan:
- Write GPIO: req addr 0x02, wdata 0xA5, PREADY0 tied 1 -> SETUP cycle with PSEL = 01, PENABLE = 0, PWRITE = 1, PADDR = 0x02, PWDATA = 0xA5; then PENABLE = 1; rsp_valid pulse 3 cycles after accept with err = 0, rdata = 0x00.
- Read UART with 2 wait states: addr 0x41, PREADY1 low for 2 ACCESS cycles then high with PRDATA1 = 0x3C -> PSEL = 10 for 4 cycles total; rsp_rdata = 0x3C, err = 0; PRDATA0 = 0xFF is ignored.
- Slave error: read addr 0x01 with PREADY0 = 1, PSLVERR0 = 1 -> rsp_err = 1, rsp_rdata = 0x00.
- Timeout: read addr 0x40, PREADY1 held 0, TIMEOUT = 16 -> exactly 16 ACCESS cycles, then PSEL/PENABLE drop, rsp_valid with err = 1, rdata = 0; a following request at addr 0x00 succeeds normally.
- Unmapped: addr 0xC0 -> PSEL stays 00 throughout; rsp_valid in the next cycle with err = 1.
- Reset mid-ACCESS: assert rst_n low during a UART wait state -> PSEL/PENABLE/rsp_valid go 0 immediately, req_ready = 1 after release, and no response pulse ever appears for the aborted request.
